pooling_window_cell: RTL and testbench

Parametrised successor to the single-channel running-max pooling cell. It reduces a window of 1..MAX_WIN consecutive IEEE-754 samples on NUM_CH parallel channels to one max or min result per channel. The window is seeded from its first sample, not from zero, so all-negative windows pool correctly. It sits between the convolution output stream and the pooled feature-map writer, with valid/ready handshakes on both sides.

---
 rtl/pool_pkg.sv | 20 ++
 rtl/pool_fp_compare.sv | 38 +++
 rtl/pooling_window_cell.sv | 141 ++++++++++++++
 tb/tb_pooling_window_cell.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and constants for the pooling window cell.
package pool_pkg;

    // Default float word: IEEE-754 single precision.
    localparam int POOL_DATA_WIDTH = 32;

    // Reduction direction, latched once per window.
    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_MIN = 1'b1
    } pool_mode_t;

    // Sign bit sits in the MSB of the float word.
    localparam int POOL_SIGN_BIT = POOL_DATA_WIDTH - 1;

    // Magnitude bits only: if both operands are zero under this mask they are
    // +0/-0 and must compare equal.
    localparam logic [POOL_DATA_WIDTH-1:0] POOL_ZERO_MASK = {1'b0, {(POOL_DATA_WIDTH-1){1'b1}}};

endpackage

// File: rtl/pool_fp_compare.sv
// Sign-magnitude float comparator: flags when b is strictly better than a
// for the selected reduction mode and returns the winner.
module pool_fp_compare
    import pool_pkg::*;
#(
    parameter int                    DATA_WIDTH = POOL_DATA_WIDTH,
    parameter int                    SIGN_BIT   = POOL_SIGN_BIT,
    parameter logic [DATA_WIDTH-1:0] ZERO_MASK  = DATA_WIDTH'(POOL_ZERO_MASK)
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  pool_mode_t            mode,
    output logic                  take_b,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] key_a;
    logic [DATA_WIDTH-1:0] key_b;
    logic                  both_zero;

    // Map each float to an unsigned key whose integer order equals float order:
    // negatives are bit-inverted, positives get the sign bit forced high.
    always_comb begin
        key_a     = a[SIGN_BIT] ? ~a : (a | ~ZERO_MASK);
        key_b     = b[SIGN_BIT] ? ~b : (b | ~ZERO_MASK);
        both_zero = ((a | b) & ZERO_MASK) == '0;
        take_b    = 1'b0;
        if (!both_zero) begin
            if (mode == POOL_MAX) begin
                take_b = key_b > key_a;
            end else begin
                take_b = key_b < key_a;
            end
        end
        result = take_b ? b : a;
    end

endmodule

// File: rtl/pooling_window_cell.sv
// Multi-channel running max/min pooling over a window of 1..MAX_WIN samples,
// seeded from the first sample, with valid/ready on both sides.
module pooling_window_cell
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = POOL_DATA_WIDTH,
    parameter int NUM_CH     = 4,
    parameter int MAX_WIN    = 16,
    parameter int CNT_W      = $clog2(MAX_WIN + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_mode,
    input  logic [CNT_W-1:0]             cfg_win,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]             out_count
);

    localparam logic [DATA_WIDTH-1:0] MAG_MASK = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] win_q;
    pool_mode_t       mode_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] out_count_q;

    logic             accept;
    logic             first;
    logic             close;
    logic [CNT_W-1:0] cfg_win_clamped;
    logic [CNT_W-1:0] eff_win;
    pool_mode_t       eff_mode;

    // One pending result is allowed; a consume frees the slot in the same cycle.
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign first     = (cnt_q == '0);
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;

    // Window length sanitising: 0 behaves as 1, oversize clamps to MAX_WIN.
    always_comb begin
        if (cfg_win == '0) begin
            cfg_win_clamped = CNT_W'(1);
        end else if (cfg_win > CNT_W'(MAX_WIN)) begin
            cfg_win_clamped = CNT_W'(MAX_WIN);
        end else begin
            cfg_win_clamped = cfg_win;
        end
    end

    // The first sample uses live config so a window can close on that sample.
    always_comb begin
        eff_win  = first ? cfg_win_clamped : win_q;
        eff_mode = first ? pool_mode_t'(cfg_mode) : mode_q;
        cnt_d    = cnt_q + CNT_W'(1);
        close    = accept && ((cnt_d == eff_win) || in_last);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] sample;
            logic [DATA_WIDTH-1:0] best;
            logic                  take_b;
            logic [DATA_WIDTH-1:0] acc_q;
            logic [DATA_WIDTH-1:0] acc_d;
            logic [DATA_WIDTH-1:0] res_q;

            assign sample = in_data[gi*DATA_WIDTH +: DATA_WIDTH];

            pool_fp_compare #(
                .DATA_WIDTH (DATA_WIDTH),
                .SIGN_BIT   (DATA_WIDTH - 1),
                .ZERO_MASK  (MAG_MASK)
            ) u_cmp (
                .a      (acc_q),
                .b      (sample),
                .mode   (eff_mode),
                .take_b (take_b),
                .result (best)
            );

            // First sample seeds the accumulator without comparing.
            assign acc_d = first ? sample : best;

            // Accumulator only loads when the seed arrives or the sample wins; ties keep acc.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_q <= '0;
                end else if (accept && (first || take_b)) begin
                    acc_q <= acc_d;
                end
            end

            // Result register captures the reduction including the closing sample.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_q <= '0;
                end else if (close) begin
                    res_q <= acc_d;
                end
            end

            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = res_q;
        end
    endgenerate

    // Window counter, per-window config latches and output handshake state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            win_q       <= CNT_W'(1);
            mode_q      <= POOL_MAX;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            if (accept) begin
                if (first) begin
                    win_q  <= cfg_win_clamped;
                    mode_q <= pool_mode_t'(cfg_mode);
                end
                cnt_q <= close ? '0 : cnt_d;
            end
            if (close) begin
                out_valid_q <= 1'b1;
                out_count_q <= cnt_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pooling_window_cell.sv
// Self-checking bench for pooling_window_cell with a float-ordering reference model.
module tb_pooling_window_cell;

    localparam int DW   = 32;
    localparam int NCH  = 4;
    localparam int MAXW = 16;
    localparam int CW   = $clog2(MAXW + 1);

    typedef logic [DW-1:0]     word_t;
    typedef logic [NCH*DW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_mode;
    logic [CW-1:0] cfg_win;
    logic          in_valid;
    logic          in_ready;
    vec_t          in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    vec_t          out_data;
    logic [CW-1:0] out_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pooling_window_cell #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .MAX_WIN    (MAXW),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mode  (cfg_mode),
        .cfg_win   (cfg_win),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    // Numeric float comparison by sign/magnitude rules: -1, 0, +1 for a<b, a==b, a>b.
    function automatic int fcmp(input word_t a, input word_t b);
        logic [DW-2:0] ma, mb;
        ma = a[DW-2:0];
        mb = b[DW-2:0];
        if (ma == 0 && mb == 0) return 0;
        if (a[DW-1] != b[DW-1]) return a[DW-1] ? -1 : 1;
        if (ma == mb) return 0;
        if (!a[DW-1]) return (ma > mb) ? 1 : -1;
        return (ma > mb) ? -1 : 1;
    endfunction

    // Reference reduction: first sample seeds, strictly better values replace.
    function automatic word_t reduce(input word_t s[$], input bit mode);
        word_t r;
        int    c;
        r = s[0];
        for (int i = 1; i < s.size(); i++) begin
            c = fcmp(s[i], r);
            if ((!mode && c > 0) || (mode && c < 0)) r = s[i];
        end
        return r;
    endfunction

    // Finite floats plus signed zeros and repeats so ties occur.
    function automatic word_t rnd_word();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'h0000_0000;
        if (sel == 1) return 32'h8000_0000;
        if (sel == 2) return 32'h3F80_0000;
        if (sel == 3) return 32'hBF80_0000;
        return {1'($urandom_range(0, 1)), 8'($urandom_range(0, 253)), 23'($urandom)};
    endfunction

    // Present one sample and wait (bounded) until it is accepted; returns at the following negedge.
    task automatic send(input vec_t d, input bit last);
        int waited;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout in_ready=%b want 1 after %0d cycles", in_ready, waited);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Feed one full window; returns the model's expected result and any premature out_valid seen.
    task automatic play_window(input bit mode, input logic [CW-1:0] win, input int last_idx,
                               input int chg_at, input logic [CW-1:0] chg_win, input word_t ch0[$],
                               output vec_t exp_d, output int exp_cnt, output int early);
        word_t q[NCH][$];
        vec_t  d;
        word_t w;
        int    eff, k;
        eff = (win == 0) ? 1 : ((int'(win) > MAXW) ? MAXW : int'(win));
        k = eff;
        if (last_idx >= 0 && last_idx + 1 < k) k = last_idx + 1;
        cfg_mode = mode;
        cfg_win  = win;
        early    = 0;
        for (int i = 0; i < k; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (ch == 0 && i < ch0.size()) w = ch0[i];
                else w = rnd_word();
                q[ch].push_back(w);
                d[ch*DW +: DW] = w;
            end
            send(d, i == last_idx);
            if (i == chg_at) begin
                cfg_win  = chg_win;
                cfg_mode = ~mode;
            end
            if (i < k - 1 && out_valid) early++;
        end
        for (int ch = 0; ch < NCH; ch++) exp_d[ch*DW +: DW] = reduce(q[ch], mode);
        exp_cnt = k;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_mode = 1'b0; cfg_win = CW'(2); in_last = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = {NCH{32'h4000_0000}};
        repeat (3) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", out_data); end
        n_vec++; if (out_count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", out_count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_max_basic();
        vec_t e; int c, early; word_t q0[$];
        q0 = '{32'h3F80_0000, 32'hC000_0000, 32'h4060_0000, 32'h3F00_0000};
        play_window(1'b0, CW'(4), -1, -1, '0, q0, e, c, early);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL max_valid got %b want 1", out_valid); end
        n_vec++; if (out_data[31:0] !== 32'h4060_0000) begin n_err++; $display("FAIL max_ch0 got %h want 40600000", out_data[31:0]); end
        n_vec++; if (out_data !== e) begin n_err++; $display("FAIL max_data got %h want %h", out_data, e); end
        n_vec++; if (out_count !== CW'(4)) begin n_err++; $display("FAIL max_count got %0d want 4", out_count); end
        n_vec++; if (early !== 0) begin n_err++; $display("FAIL max_early got %0d want 0", early); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL max_onecycle got %b want 0", out_valid); end
        $display("test_max_basic result ch0=%h count=%0d", out_data[31:0], c);
    endtask

    task automatic test_negative_and_min();
        vec_t e; int c, early; word_t q0[$];
        q0 = '{32'hBF80_0000, 32'hC040_0000, 32'hBF00_0000};
        play_window(1'b0, CW'(3), -1, -1, '0, q0, e, c, early);
        n_vec++; if (out_data[31:0] !== 32'hBF00_0000) begin n_err++; $display("FAIL neg_max_ch0 got %h want bf000000", out_data[31:0]); end
        n_vec++; if (out_data !== e) begin n_err++; $display("FAIL neg_max_data got %h want %h", out_data, e); end
        n_vec++; if (out_count !== CW'(3)) begin n_err++; $display("FAIL neg_max_count got %0d want 3", out_count); end
        play_window(1'b1, CW'(3), -1, -1, '0, q0, e, c, early);
        n_vec++; if (out_data[31:0] !== 32'hC040_0000) begin n_err++; $display("FAIL min_ch0 got %h want c0400000", out_data[31:0]); end
        n_vec++; if (out_data !== e) begin n_err++; $display("FAIL min_data got %h want %h", out_data, e); end
        q0 = '{32'h8000_0000, 32'h0000_0000};
        play_window(1'b1, CW'(2), -1, -1, '0, q0, e, c, early);
        n_vec++; if (out_data[31:0] !== 32'h8000_0000) begin n_err++; $display("FAIL zero_tie_ch0 got %h want 80000000", out_data[31:0]); end
        n_vec++; if (out_count !== CW'(2)) begin n_err++; $display("FAIL zero_tie_count got %0d want 2", out_count); end
        $display("test_negative_and_min tie ch0=%h", out_data[31:0]);
    endtask

    task automatic test_window_control();
        vec_t e; int c, early; word_t q0[$];
        q0 = {};
        play_window(1'b0, CW'(4), 1, -1, '0, q0, e, c, early);
        n_vec++; if (out_count !== CW'(2)) begin n_err++; $display("FAIL last_count got %0d want 2", out_count); end
        n_vec++; if (out_data !== e) begin n_err++; $display("FAIL last_data got %h want %h", out_data, e); end
        play_window(1'b1, CW'(4), -1, 0, CW'(2), q0, e, c, early);
        n_vec++; if (out_count !== CW'(4) || early !== 0) begin n_err++; $display("FAIL midchange_count got %0d/%0d want 4/0", out_count, early); end
        n_vec++; if (out_data !== e) begin n_err++; $display("FAIL midchange_data got %h want %h", out_data, e); end
        play_window(1'b0, CW'(2), -1, -1, '0, q0, e, c, early);
        n_vec++; if (out_count !== CW'(2)) begin n_err++; $display("FAIL next_win_count got %0d want 2", out_count); end
        play_window(1'b0, CW'(0), -1, -1, '0, q0, e, c, early);
        n_vec++; if (out_count !== CW'(1) || out_valid !== 1'b1) begin n_err++; $display("FAIL win0_count got %0d/%b want 1/1", out_count, out_valid); end
        n_vec++; if (out_data !== e) begin n_err++; $display("FAIL win0_data got %h want %h", out_data, e); end
        play_window(1'b0, CW'(31), -1, -1, '0, q0, e, c, early);
        n_vec++; if (out_count !== CW'(16) || early !== 0) begin n_err++; $display("FAIL clamp_count got %0d/%0d want 16/0", out_count, early); end
        n_vec++; if (out_data !== e) begin n_err++; $display("FAIL clamp_data got %h want %h", out_data, e); end
        play_window(1'b1, CW'(5), 0, -1, '0, q0, e, c, early);
        n_vec++; if (out_count !== CW'(1)) begin n_err++; $display("FAIL last_first_count got %0d want 1", out_count); end
        @(negedge clk);
        $display("test_window_control done");
    endtask

    task automatic test_back_to_back();
        vec_t e, ea, b1, b2; int c, early; word_t q0[$]; word_t pair[$];
        q0 = {};
        out_ready = 1'b0;
        play_window(1'b0, CW'(2), -1, -1, '0, q0, ea, c, early);
        n_vec++; if (out_valid !== 1'b1 || out_data !== ea) begin n_err++; $display("FAIL bp_first got %b/%h want 1/%h", out_valid, out_data, ea); end
        for (int ch = 0; ch < NCH; ch++) begin
            b1[ch*DW +: DW] = rnd_word();
            b2[ch*DW +: DW] = rnd_word();
        end
        cfg_win = CW'(2); cfg_mode = 1'b0;
        in_data = b1; in_last = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b want 0", in_ready); end
            n_vec++; if (out_data !== ea || out_valid !== 1'b1 || out_count !== CW'(2)) begin n_err++; $display("FAIL bp_stable got %h/%b/%0d want %h/1/2", out_data, out_valid, out_count, ea); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_consume got %b want 0", out_valid); end
        send(b2, 1'b0);
        for (int ch = 0; ch < NCH; ch++) begin
            pair = '{b1[ch*DW +: DW], b2[ch*DW +: DW]};
            e[ch*DW +: DW] = reduce(pair, 1'b0);
        end
        n_vec++; if (out_valid !== 1'b1 || out_data !== e || out_count !== CW'(2)) begin n_err++; $display("FAIL bp_second got %b/%h/%0d want 1/%h/2", out_valid, out_data, out_count, e); end
        // Single-sample windows with out_ready high: each close overlaps the previous consume.
        for (int i = 0; i < 3; i++) begin
            play_window(i[0], CW'(1), -1, -1, '0, q0, e, c, early);
            n_vec++; if (out_valid !== 1'b1 || out_data !== e || out_count !== CW'(1)) begin n_err++; $display("FAIL b2b_win1 got %b/%h/%0d want 1/%h/1", out_valid, out_data, out_count, e); end
        end
        @(negedge clk);
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_midwindow();
        vec_t e, big; int c, early; word_t q0[$];
        q0 = {};
        out_ready = 1'b0;
        play_window(1'b0, CW'(1), -1, -1, '0, q0, e, c, early);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_data !== '0) begin n_err++; $display("FAIL rst_pending got %b/%h want 0/0", out_valid, out_data); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        cfg_win = CW'(4); cfg_mode = 1'b0;
        big = {NCH{32'h7F00_0000}};
        send(big, 1'b0);
        send(big, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0) begin n_err++; $display("FAIL rst_partial got %b/%h/%0d want 0/0/0", out_valid, out_data, out_count); end
        @(negedge clk);
        rst = 1'b0;
        play_window(1'b0, CW'(4), -1, -1, '0, q0, e, c, early);
        n_vec++; if (out_count !== CW'(4) || early !== 0) begin n_err++; $display("FAIL rst_fresh_count got %0d/%0d want 4/0", out_count, early); end
        n_vec++; if (out_data !== e) begin n_err++; $display("FAIL rst_fresh_data got %h want %h", out_data, e); end
        @(negedge clk);
        $display("test_reset_midwindow done");
    endtask

    task automatic test_random();
        vec_t e; int c, early, last_idx; bit mode; logic [CW-1:0] win; word_t q0[$];
        q0 = {};
        out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            mode     = 1'($urandom_range(0, 1));
            win      = CW'($urandom_range(0, 20));
            last_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            play_window(mode, win, last_idx, -1, '0, q0, e, c, early);
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== e || out_count !== CW'(c) || early !== 0) begin
                n_err++;
                $display("FAIL rand_%0d got v=%b d=%h n=%0d early=%0d want v=1 d=%h n=%0d early=0", n, out_valid, out_data, out_count, early, e, c);
            end
            $display("rand window %0d mode=%0d win=%0d count=%0d", n, mode, win, c);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_mode = 1'b0; cfg_win = '0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_max_basic();
        test_negative_and_min();
        test_window_control();
        test_back_to_back();
        test_reset_midwindow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
